// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2
// Purpose  : Two-master round-robin Wishbone arbiter sharing one slave port.
//            Ownership lasts for the whole cyc assertion, so bursts and RMW
//            sequences stay atomic. The losing master stalls with ack/err low.
// Options  : WB_ARB2_TIMEOUT_EN - adds a stall watchdog that errors out and
//            releases a master whose slave never responds.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
  parameter int adr_width      = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // master 0
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  // master 1
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  // shared slave
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       last_rr;      // last master served; the other one wins a tie
  logic       req0;         // effective arbitration requests
  logic       req1;
  logic       timeout_hit;  // watchdog fires this cycle

`ifdef WB_ARB2_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             blk0;   // master held off until it drops cyc
  logic             blk1;
  logic             own_stall;

  // owner is strobing the slave and the slave has not answered yet
  assign own_stall = (((state == GNT0) && m0_cyc_i && m0_stb_i) ||
                      ((state == GNT1) && m1_cyc_i && m1_stb_i)) &&
                     !s_ack_i && !s_err_i;

  // the stall that would push the count to the limit is the timeout cycle
  assign timeout_hit = own_stall && (tmo_cnt == CNT_W'(timeout_cycles - 1));

  // count consecutive unanswered strobe cycles of the current owner
  always_ff @(posedge clk) begin
    if (reset || s_ack_i || s_err_i || timeout_hit || (state != next_state))
      tmo_cnt <= '0;
    else if (own_stall)
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // a timed-out master is ignored until it deasserts cyc
  always_ff @(posedge clk) begin
    if (reset) begin
      blk0 <= 1'b0;
      blk1 <= 1'b0;
    end else begin
      if (timeout_hit && (state == GNT0)) blk0 <= 1'b1;
      else if (!m0_cyc_i)                 blk0 <= 1'b0;
      if (timeout_hit && (state == GNT1)) blk1 <= 1'b1;
      else if (!m1_cyc_i)                 blk1 <= 1'b0;
    end
  end

  assign req0 = m0_cyc_i && !blk0;
  assign req1 = m1_cyc_i && !blk1;
`else
  // no watchdog in this build; the limit parameter has no effect
  logic unused_timeout;
  assign unused_timeout = (timeout_cycles == 0);
  assign timeout_hit    = 1'b0;
  assign req0           = m0_cyc_i;
  assign req1           = m1_cyc_i;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // remember who was granted last, updated on entry to a grant state
  always_ff @(posedge clk) begin
    if (reset)
      last_rr <= 1'b1;
    else if ((state != GNT0) && (next_state == GNT0))
      last_rr <= 1'b0;
    else if ((state != GNT1) && (next_state == GNT1))
      last_rr <= 1'b1;
  end

  // next-state: round-robin from idle, hand over directly on release
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  next_state = last_rr ? GNT0 : GNT1;
        else if (req0)     next_state = GNT0;
        else if (req1)     next_state = GNT1;
      end
      GNT0: begin
        if (!req0 || timeout_hit) next_state = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!req1 || timeout_hit) next_state = req0 ? GNT0 : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // output routing: owner's bus to the slave, slave responses to the owner
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i && !timeout_hit;
        s_stb_o  = m0_cyc_i && m0_stb_i && !timeout_hit;
        // responses after an abort (cyc low) are dropped
        m0_ack_o = s_ack_i && s_cyc_o;
        m0_err_o = (s_err_i && s_cyc_o) || timeout_hit;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i && !timeout_hit;
        s_stb_o  = m1_cyc_i && m1_stb_i && !timeout_hit;
        m1_ack_o = s_ack_i && s_cyc_o;
        m1_err_o = (s_err_i && s_cyc_o) || timeout_hit;
      end
      default: ;
    endcase
  end

  // read data is broadcast; only the owner sees an ack
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
`default_nettype wire
